// File: rtl/hires_pixel_serializer_pkg.sv
// Shared encodings and helpers for the hires pixel serializer and its
// reusable fetch-delay pipeline.
package hires_seq_pkg;

  // Bits-per-pixel selector encodings.
  typedef enum logic [1:0] {
    BPP_1   = 2'b00,
    BPP_2   = 2'b01,
    BPP_4   = 2'b10,
    BPP_INV = 2'b11
  } bpp_e;

  // Horizontal pixel-repeat selector encodings; 11 behaves as x4.
  typedef enum logic [1:0] {
    REP_X1  = 2'b00,
    REP_X2  = 2'b01,
    REP_X4  = 2'b10,
    REP_X4B = 2'b11
  } rep_e;

  // Resolved output of the colour stage.
  typedef struct packed {
    logic [3:0] color;
    logic       is_bg;
  } pix_out_t;

  // Shifter advance per pixel; the invalid mode does not consume bits.
  function automatic logic [2:0] bpp_width(input logic [1:0] bpp_sel);
    logic [2:0] w;
    case (bpp_e'(bpp_sel))
      BPP_1:   w = 3'd1;
      BPP_2:   w = 3'd2;
      BPP_4:   w = 3'd4;
      default: w = 3'd0;
    endcase
    return w;
  endfunction

  // Number of hires dots each pixel is held for.
  function automatic logic [2:0] rep_count(input logic [1:0] rep_sel);
    logic [2:0] r;
    case (rep_e'(rep_sel))
      REP_X1:  r = 3'd1;
      REP_X2:  r = 3'd2;
      default: r = 3'd4;
    endcase
    return r;
  endfunction

  // Maps a right-aligned pixel value to a palette index plus the
  // background flag used for sprite priority. Border overrides everything.
  function automatic pix_out_t map_color(
    input logic       border,
    input logic [1:0] bpp_sel,
    input logic [3:0] v,
    input logic [3:0] fg_color,
    input logic [3:0] b0c,
    input logic [3:0] ec,
    input logic [3:0] color_base
  );
    pix_out_t o;
    o.color = b0c;
    o.is_bg = 1'b1;
    if (border) begin
      o.color = ec;
      o.is_bg = 1'b0;
    end else begin
      case (bpp_e'(bpp_sel))
        BPP_1: begin
          o.color = v[0] ? fg_color : b0c;
          o.is_bg = !v[0];
        end
        BPP_2: begin
          o.color = {color_base[1:0], v[1:0]};
          o.is_bg = (o.color == b0c);
        end
        BPP_4: begin
          o.color = v;
          o.is_bg = (o.color == b0c);
        end
        default: begin
          o.color = b0c;
          o.is_bg = 1'b1;
        end
      endcase
    end
    return o;
  endfunction

endpackage

// File: rtl/hires_pixel_serializer_if.sv
// Bus between the hires fetch/timing logic (master) and the pixel
// serializer (slave), including the colour-index result towards the mux.
interface hires_pixel_serializer_if #(
  parameter int DATA_W   = 16,
  parameter int SCROLL_W = 4
);
  logic                hires_tick;
  logic                fetch_strobe;
  logic                load_strobe;
  logic [DATA_W-1:0]   fetch_data;
  logic                fetch_visible;
  logic                vborder;
  logic                main_border;
  logic [SCROLL_W-1:0] hires_dot_idx;
  logic [SCROLL_W-1:0] xscroll;
  logic [1:0]          bpp_sel;
  logic [1:0]          rep_sel;
  logic [3:0]          fg_color;
  logic [3:0]          b0c;
  logic [3:0]          ec;
  logic [3:0]          color_base;
  logic [3:0]          pixel_color;
  logic                pixel_valid;
  logic                is_background;

  modport master (
    output hires_tick, fetch_strobe, load_strobe, fetch_data, fetch_visible,
           vborder, main_border, hires_dot_idx, xscroll, bpp_sel, rep_sel,
           fg_color, b0c, ec, color_base,
    input  pixel_color, pixel_valid, is_background
  );

  modport slave (
    input  hires_tick, fetch_strobe, load_strobe, fetch_data, fetch_visible,
           vborder, main_border, hires_dot_idx, xscroll, bpp_sel, rep_sel,
           fg_color, b0c, ec, color_base,
    output pixel_color, pixel_valid, is_background
  );
endinterface

// File: rtl/hires_pixel_serializer_fetch_delay.sv
// Strobe-enabled shift pipeline aligning fetched words with the display
// position. Generic width so the sprite path can reuse it.
module hires_fetch_delay #(
  parameter int DELAY = 5,
  parameter int WIDTH = 17
) (
  input  logic             clk_dot4x,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] line [DELAY];

  // Shift one entry per strobe; synchronous active-low clear empties the line.
  always_ff @(posedge clk_dot4x) begin
    if (!rst) begin
      for (int i = 0; i < DELAY; i++) line[i] <= '0;
    end else if (en) begin
      line[0] <= din;
      for (int i = 1; i < DELAY; i++) line[i] <= line[i-1];
    end
  end

  assign dout = line[DELAY-1];

endmodule

// File: rtl/hires_pixel_serializer.sv
// Hires pixel serializer: delays fetched words, loads them at the scrolled
// dot position and shifts out 1/2/4-bit pixels with 1x/2x/4x repeat, then
// maps them to a colour index with a background flag.
module hires_pixel_serializer
  import hires_seq_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int DELAY    = 5,
  parameter int SCROLL_W = 4
) (
  input  logic                     clk_dot4x,
  input  logic                     rst,
  hires_pixel_serializer_if.slave  bus
);

  logic [DATA_W:0]     tail;
  logic [DATA_W:0]     hold_word;
  logic [SCROLL_W-1:0] xscroll_l;
  logic [DATA_W-1:0]   shifter;
  logic [1:0]          rep_ctr;

  logic [DATA_W-1:0]   shifter_nxt;
  logic [1:0]          rep_ctr_nxt;
  logic [2:0]          bw;
  logic [2:0]          rep;
  logic                load_now;
  logic                rep_last;
  logic [DATA_W-1:0]   load_word;
  logic [3:0]          top4;
  logic [3:0]          pix_nxt;

  logic [3:0]          pix_p0;
  logic                border_p0;
  logic [3:0]          b0c_p0;
  logic [3:0]          ec_p0;
  logic [1:0]          bpp_p0;
  logic                vld_p0;

  pix_out_t            out_nxt;

  hires_fetch_delay #(
    .DELAY (DELAY),
    .WIDTH (DATA_W + 1)
  ) u_fetch_delay (
    .clk_dot4x (clk_dot4x),
    .rst       (rst),
    .en        (bus.fetch_strobe),
    .din       ({bus.fetch_visible, bus.fetch_data}),
    .dout      (tail)
  );

  // Holding word and latched scroll; scroll only updates outside vborder.
  always_ff @(posedge clk_dot4x) begin
    if (!rst) begin
      hold_word <= '0;
      xscroll_l <= '0;
    end else if (bus.load_strobe) begin
      hold_word <= tail;
      if (!bus.vborder) xscroll_l <= bus.xscroll;
    end
  end

  // Next shifter state: a load at the scroll position beats a repeat-driven
  // advance, and the presented pixel is taken after the update so the load
  // tick shows the new word's MSBs immediately.
  always_comb begin
    bw          = bpp_width(bus.bpp_sel);
    rep         = rep_count(bus.rep_sel);
    load_now    = (bus.hires_dot_idx == xscroll_l);
    load_word   = (hold_word[DATA_W] && !bus.vborder) ? hold_word[DATA_W-1:0] : '0;
    rep_last    = ({1'b0, rep_ctr} >= (rep - 3'd1));
    shifter_nxt = shifter;
    rep_ctr_nxt = rep_ctr;
    if (load_now) begin
      shifter_nxt = load_word;
      rep_ctr_nxt = 2'd0;
    end else if (rep_last) begin
      shifter_nxt = shifter << bw;
      rep_ctr_nxt = 2'd0;
    end else begin
      rep_ctr_nxt = rep_ctr + 2'd1;
    end
    top4 = shifter_nxt[DATA_W-1 -: 4];
    case (bpp_e'(bus.bpp_sel))
      BPP_1:   pix_nxt = {3'b000, top4[3]};
      BPP_2:   pix_nxt = {2'b00, top4[3:2]};
      default: pix_nxt = top4;
    endcase
  end

  // ---- stage 0: shifter update and pixel capture on each hires tick ----
  always_ff @(posedge clk_dot4x) begin
    if (!rst) begin
      shifter <= '0;
      rep_ctr <= 2'd0;
      vld_p0  <= 1'b0;
    end else begin
      vld_p0 <= bus.hires_tick;
      if (bus.hires_tick) begin
        shifter   <= shifter_nxt;
        rep_ctr   <= rep_ctr_nxt;
        pix_p0    <= pix_nxt;
        border_p0 <= bus.main_border;
        b0c_p0    <= bus.b0c;
        ec_p0     <= bus.ec;
        bpp_p0    <= bus.bpp_sel;
      end
    end
  end

  // Colour mapping of the captured pixel.
  always_comb begin
    out_nxt = map_color(border_p0, bpp_p0, pix_p0, bus.fg_color, b0c_p0,
                        ec_p0, bus.color_base);
  end

  // ---- stage 1: registered colour index, background flag and strobe ----
  always_ff @(posedge clk_dot4x) begin
    if (!rst) begin
      bus.pixel_color   <= 4'd0;
      bus.pixel_valid   <= 1'b0;
      bus.is_background <= 1'b1;
    end else begin
      bus.pixel_valid <= vld_p0;
      if (vld_p0) begin
        bus.pixel_color   <= out_nxt.color;
        bus.is_background <= out_nxt.is_bg;
      end
    end
  end

endmodule

// File: tb/tb_hires_pixel_serializer.sv
// Bench for hires_pixel_serializer: directed scenarios plus randomized
// periods, checked against a bit-offset reference model of the display.
module tb_hires_pixel_serializer;
  localparam int DATA_W   = 16;
  localparam int DELAY    = 5;
  localparam int SCROLL_W = 4;

  logic clk_dot4x = 1'b0;
  logic rst       = 1'b0;
  always #5 clk_dot4x = ~clk_dot4x;

  hires_pixel_serializer_if #(.DATA_W(DATA_W), .SCROLL_W(SCROLL_W)) bus ();

  hires_pixel_serializer #(
    .DATA_W   (DATA_W),
    .DELAY    (DELAY),
    .SCROLL_W (SCROLL_W)
  ) dut (
    .clk_dot4x (clk_dot4x),
    .rst       (rst),
    .bus       (bus.slave)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: queue of fetched words, holding word, latched scroll,
  // and the displayed word tracked as a bit offset plus repeat count.
  logic [DATA_W:0]   m_line [DELAY];
  logic [DATA_W:0]   m_hold;
  int                m_xs;
  logic [DATA_W-1:0] m_word;
  int                m_pos;
  int                m_cnt;

  logic [3:0] obs_col [16];
  logic       obs_bg  [16];

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int bw_of(input logic [1:0] s);
    case (s)
      2'b00:   return 1;
      2'b01:   return 2;
      2'b10:   return 4;
      default: return 0;
    endcase
  endfunction

  function automatic int rep_of(input logic [1:0] s);
    case (s)
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  // Bits of the word at bit offset pos (MSB = offset 0); beyond the end reads 0.
  function automatic logic [3:0] bits_at(input logic [DATA_W-1:0] w, input int pos, input int b);
    logic [2*DATA_W-1:0] ext;
    if (b == 0 || pos >= DATA_W) return 4'd0;
    ext = {w, {DATA_W{1'b0}}};
    return 4'((ext >> (2*DATA_W - pos - b)) & ((1 << b) - 1));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DELAY; i++) m_line[i] = '0;
    m_hold = '0;
    m_xs   = 0;
    m_word = '0;
    m_pos  = 0;
    m_cnt  = 1;
  endtask

  // One hires dot: tick, check strobe timing and colour, then optional strobes.
  task automatic do_dot(input int idx, input logic border, input logic fetch,
                        input logic [DATA_W-1:0] fw, input logic fvis, input logic load);
    logic [3:0] v;
    logic [3:0] e_col;
    logic       e_bg;
    @(negedge clk_dot4x);
    bus.hires_dot_idx = SCROLL_W'(idx);
    bus.main_border   = border;
    bus.hires_tick    = 1'b1;
    if (idx == m_xs) begin
      m_word = (m_hold[DATA_W] && !bus.vborder) ? m_hold[DATA_W-1:0] : '0;
      m_pos  = 0;
      m_cnt  = 1;
    end else if (m_cnt >= rep_of(bus.rep_sel)) begin
      m_pos = m_pos + bw_of(bus.bpp_sel);
      if (m_pos > DATA_W) m_pos = DATA_W;
      m_cnt = 1;
    end else begin
      m_cnt++;
    end
    v = bits_at(m_word, m_pos, bw_of(bus.bpp_sel));
    if (border) begin
      e_col = bus.ec; e_bg = 1'b0;
    end else begin
      case (bus.bpp_sel)
        2'b00: begin e_col = v[0] ? bus.fg_color : bus.b0c; e_bg = !v[0]; end
        2'b01: begin e_col = {bus.color_base[1:0], v[1:0]}; e_bg = (e_col == bus.b0c); end
        2'b10: begin e_col = v; e_bg = (e_col == bus.b0c); end
        default: begin e_col = bus.b0c; e_bg = 1'b1; end
      endcase
    end
    @(negedge clk_dot4x);
    bus.hires_tick = 1'b0;
    chk("valid_early", {7'd0, bus.pixel_valid}, 8'd0);
    @(negedge clk_dot4x);
    chk("valid_on", {7'd0, bus.pixel_valid}, 8'd1);
    chk($sformatf("color_dot%0d", idx), {4'd0, bus.pixel_color}, {4'd0, e_col});
    chk($sformatf("bg_dot%0d", idx), {7'd0, bus.is_background}, {7'd0, e_bg});
    obs_col[idx] = bus.pixel_color;
    obs_bg[idx]  = bus.is_background;
    @(negedge clk_dot4x);
    chk("valid_late", {7'd0, bus.pixel_valid}, 8'd0);
    bus.fetch_strobe  = fetch;
    bus.load_strobe   = load;
    bus.fetch_data    = fw;
    bus.fetch_visible = fvis;
    if (load) begin
      m_hold = m_line[DELAY-1];
      if (!bus.vborder) m_xs = int'(bus.xscroll);
    end
    if (fetch) begin
      for (int i = DELAY - 1; i > 0; i--) m_line[i] = m_line[i-1];
      m_line[0] = {fvis, fw};
    end
    @(negedge clk_dot4x);
    bus.fetch_strobe = 1'b0;
    bus.load_strobe  = 1'b0;
  endtask

  // One word period of 16 dots starting at first_dot; fetch+load on the last dot.
  // bmode: 0 no border, 1 all border, 2 random border. sw_dot switches bpp.
  task automatic run_period(input logic [DATA_W-1:0] fw, input logic fvis,
                            input int bmode, input int first_dot,
                            input int sw_dot, input logic [1:0] sw_bpp);
    logic b;
    for (int d = first_dot; d < 16; d++) begin
      if (d == sw_dot) bus.bpp_sel = sw_bpp;
      b = (bmode == 1) ? 1'b1 : (bmode == 2) ? ($urandom_range(0, 7) == 0) : 1'b0;
      do_dot(d, b, d == 15, fw, fvis, d == 15);
    end
  endtask

  // Fetch w, push it through the delay line, then display it in the final period.
  task automatic show_word(input logic [DATA_W-1:0] w, input logic vis, input logic vb_disp,
                           input int bmode_disp, input int sw_dot, input logic [1:0] sw_bpp);
    run_period(w, vis, 0, 0, -1, 2'b00);
    repeat (DELAY) run_period(DATA_W'($urandom), 1'b1, 0, 0, -1, 2'b00);
    bus.vborder = vb_disp;
    run_period(DATA_W'($urandom), 1'b1, bmode_disp, 0, sw_dot, sw_bpp);
    bus.vborder = 1'b0;
  endtask

  task automatic set_cfg(input logic [1:0] bpp, input logic [1:0] rep, input int xs,
                         input logic [3:0] fg, input logic [3:0] b0, input logic [3:0] e,
                         input logic [3:0] cb);
    bus.bpp_sel    = bpp;
    bus.rep_sel    = rep;
    bus.xscroll    = SCROLL_W'(xs);
    bus.fg_color   = fg;
    bus.b0c        = b0;
    bus.ec         = e;
    bus.color_base = cb;
  endtask

  initial begin
    logic [3:0] exp1 [16];
    logic [3:0] exp2 [16];
    int hits;
    exp1 = '{4'd1, 4'd6, 4'd1, 4'd6, 4'd6, 4'd1, 4'd6, 4'd1,
             4'd1, 4'd1, 4'd1, 4'd1, 4'd6, 4'd6, 4'd6, 4'd6};
    exp2 = '{4'd8, 4'd8, 4'd9, 4'd9, 4'd10, 4'd10, 4'd11, 4'd11,
             4'd8, 4'd8, 4'd8, 4'd8, 4'd8, 4'd8, 4'd8, 4'd8};
    bus.hires_tick    = 1'b0;
    bus.fetch_strobe  = 1'b0;
    bus.load_strobe   = 1'b0;
    bus.fetch_data    = '0;
    bus.fetch_visible = 1'b0;
    bus.vborder       = 1'b0;
    bus.main_border   = 1'b0;
    bus.hires_dot_idx = '0;
    set_cfg(2'b00, 2'b00, 0, 4'd1, 4'd6, 4'd3, 4'd0);
    model_reset();

    // Reset state
    rst = 1'b0;
    repeat (3) @(negedge clk_dot4x);
    chk("rst_color", {4'd0, bus.pixel_color}, 8'd0);
    chk("rst_valid", {7'd0, bus.pixel_valid}, 8'd0);
    chk("rst_bg", {7'd0, bus.is_background}, 8'd1);
    rst = 1'b1;

    // 1bpp x1, no scroll
    set_cfg(2'b00, 2'b00, 0, 4'd1, 4'd6, 4'd3, 4'd0);
    show_word(16'hA5F0, 1'b1, 1'b0, 0, -1, 2'b00);
    for (int i = 0; i < 16; i++) chk($sformatf("t1_dot%0d", i), {4'd0, obs_col[i]}, {4'd0, exp1[i]});

    // 2bpp x2 with colour base 10
    set_cfg(2'b01, 2'b01, 0, 4'd1, 4'd0, 4'd3, 4'b0010);
    show_word(16'h1B00, 1'b1, 1'b0, 0, -1, 2'b00);
    for (int i = 0; i < 16; i++) chk($sformatf("t2_dot%0d", i), {4'd0, obs_col[i]}, {4'd0, exp2[i]});

    // 4bpp x4, scroll 3, background equal to the first nibble
    set_cfg(2'b10, 2'b10, 3, 4'd1, 4'hC, 4'd3, 4'd0);
    show_word(16'hC5A0, 1'b1, 1'b0, 0, -1, 2'b00);
    for (int i = 3; i < 7; i++) begin
      chk($sformatf("t3_col%0d", i), {4'd0, obs_col[i]}, 8'h0C);
      chk($sformatf("t3_bg%0d", i), {7'd0, obs_bg[i]}, 8'd1);
    end
    chk("t3_col7", {4'd0, obs_col[7]}, 8'h05);
    chk("t3_bg7", {7'd0, obs_bg[7]}, 8'd0);

    // Invisible word and vborder both blank the loaded word; main border wins
    set_cfg(2'b00, 2'b00, 0, 4'd1, 4'd6, 4'd9, 4'd0);
    show_word(16'hFFFF, 1'b0, 1'b0, 0, -1, 2'b00);
    hits = 0;
    for (int i = 0; i < 16; i++) if (obs_col[i] != 4'd6) hits++;
    chk("invisible_blank", 8'(hits), 8'd0);
    show_word(16'hFFFF, 1'b1, 1'b1, 0, -1, 2'b00);
    hits = 0;
    for (int i = 0; i < 16; i++) if (obs_col[i] != 4'd6 || obs_bg[i] != 1'b1) hits++;
    chk("vborder_blank", 8'(hits), 8'd0);
    show_word(16'hFFFF, 1'b1, 1'b0, 1, -1, 2'b00);
    hits = 0;
    for (int i = 0; i < 16; i++) if (obs_col[i] != 4'd9 || obs_bg[i] != 1'b0) hits++;
    chk("main_border", 8'(hits), 8'd0);

    // Reset mid-word while displaying 0xFFFF
    repeat (DELAY + 1) run_period(16'hFFFF, 1'b1, 0, 0, -1, 2'b00);
    for (int d = 0; d < 6; d++) do_dot(d, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    chk("pre_rst_fg", {4'd0, obs_col[5]}, 8'd1);
    @(negedge clk_dot4x);
    rst = 1'b0;
    @(negedge clk_dot4x);
    rst = 1'b1;
    model_reset();
    chk("midrst_color", {4'd0, bus.pixel_color}, 8'd0);
    chk("midrst_valid", {7'd0, bus.pixel_valid}, 8'd0);
    chk("midrst_bg", {7'd0, bus.is_background}, 8'd1);
    run_period(16'h8001, 1'b1, 0, 6, -1, 2'b00);
    for (int p = 0; p < DELAY; p++) begin
      run_period(DATA_W'($urandom), 1'b1, 0, 0, -1, 2'b00);
      hits = 0;
      for (int i = 0; i < 16; i++) if (obs_col[i] != 4'd6) hits++;
      chk($sformatf("post_rst_zero%0d", p), 8'(hits), 8'd0);
    end
    run_period(DATA_W'($urandom), 1'b1, 0, 0, -1, 2'b00);
    chk("fresh_dot0", {4'd0, obs_col[0]}, 8'd1);
    chk("fresh_dot1", {4'd0, obs_col[1]}, 8'd6);
    chk("fresh_dot15", {4'd0, obs_col[15]}, 8'd1);

    // Invalid bpp shows background for every dot
    set_cfg(2'b11, 2'b00, 0, 4'd1, 4'd6, 4'd3, 4'd0);
    show_word(16'h6C3F, 1'b1, 1'b0, 0, -1, 2'b00);
    hits = 0;
    for (int i = 0; i < 16; i++) if (obs_col[i] != 4'd6 || obs_bg[i] != 1'b1) hits++;
    chk("invalid_bpp", 8'(hits), 8'd0);
    // Switch from invalid to 2bpp mid-word; the model covers the continuation
    set_cfg(2'b11, 2'b00, 0, 4'd1, 4'd6, 4'd3, 4'b0001);
    show_word(16'h6C3F, 1'b1, 1'b0, 0, 8, 2'b01);

    // Randomized periods with random configuration, scroll, borders and visibility
    for (int p = 0; p < 30; p++) begin
      set_cfg(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), $urandom_range(0, 15),
              4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
      bus.vborder = ($urandom_range(0, 7) == 0);
      run_period(DATA_W'($urandom), $urandom_range(0, 3) != 0, 2, 0, -1, 2'b00);
      bus.vborder = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
